// File: rtl/led_pkg.sv
// Shared types for the LED pattern generator.
// Pattern select codes and breathe ramp direction.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_SOLID   = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } br_state_t;

endpackage

// File: rtl/pwm_timebase.sv
// Prescaled PWM timebase: tick every PRESC clocks,
// PWM counter advancing on tick, period_end on wrap.
module pwm_timebase #(
    parameter int PRESC = 4,
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [PWM_W-1:0] cnt,
    output logic             period_end
);

    localparam int PCNT_W = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PRESC - 1);

    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [PWM_W-1:0]  cnt_q, cnt_d;
    logic              tick;

    always_comb begin
        tick       = en && (pcnt_q == PCNT_MAX);
        period_end = tick && (cnt_q == '1);
        pcnt_d     = pcnt_q + 1'b1;
        cnt_d      = cnt_q;
        if (!en) begin
            pcnt_d = '0;
            cnt_d  = '0;
        end else if (tick) begin
            pcnt_d = '0;
            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
            cnt_q  <= '0;
        end else begin
            pcnt_q <= pcnt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/led_breathe.sv
// User LED pattern generator: off, solid, blink or
// breathe (triangular PWM duty ramp), registered output.
module led_breathe
    import led_pkg::*;
#(
    parameter int PWM_W = 8,
    parameter int PRESC = 4,
    parameter int HOLD  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] mode,
    output logic       led,
    output logic       period_done
);

    localparam int HCNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(HOLD - 1);

    logic [PWM_W-1:0]  cnt;
    logic              period_end;
    mode_t             mode_in;
    logic              mode_chg;
    logic              step;
    logic              clr;

    mode_t             mode_q, mode_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic [PWM_W-1:0]  duty_q, duty_d;
    br_state_t         state_q, state_d;
    logic              blink_ph_q, blink_ph_d;
    logic              led_q, led_d;
    logic              period_done_q, period_done_d;

    pwm_timebase #(
        .PRESC (PRESC),
        .PWM_W (PWM_W)
    ) u_tb (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cnt        (cnt),
        .period_end (period_end)
    );

    // A mode change clears the pattern state and wins over a same-cycle step.
    always_comb begin
        mode_in  = mode_t'(mode);
        mode_chg = (mode_in != mode_q);
        clr      = !en || mode_chg;
        step     = period_end && (hcnt_q == HCNT_MAX);
        mode_d   = en ? mode_in : MODE_OFF;
        hcnt_d   = hcnt_q;
        blink_ph_d = blink_ph_q;
        if (clr) begin
            hcnt_d     = '0;
            blink_ph_d = 1'b0;
        end else if (period_end) begin
            hcnt_d     = step ? '0 : hcnt_q + 1'b1;
            blink_ph_d = step ? ~blink_ph_q : blink_ph_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = UP;
        end else if (step) begin
            unique case (state_q)
                UP:   if (duty_q == '1) state_d = DOWN;
                DOWN: if (duty_q == '0) state_d = UP;
                default: state_d = UP;
            endcase
        end
    end

    // Duty bounces off the rails instead of wrapping.
    always_comb begin
        duty_d = duty_q;
        if (clr) begin
            duty_d = '0;
        end else if (step) begin
            unique case (state_q)
                UP:   duty_d = (duty_q == '1) ? duty_q - 1'b1 : duty_q + 1'b1;
                DOWN: duty_d = (duty_q == '0) ? duty_q + 1'b1 : duty_q - 1'b1;
                default: duty_d = '0;
            endcase
        end
    end

    always_comb begin
        led_d         = 1'b0;
        period_done_d = period_end;
        if (en) begin
            unique case (mode_in)
                MODE_OFF:     led_d = 1'b0;
                MODE_SOLID:   led_d = 1'b1;
                MODE_BLINK:   led_d = !mode_chg && blink_ph_q;
                MODE_BREATHE: led_d = !mode_chg && (cnt < duty_q);
                default:      led_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q        <= MODE_OFF;
            hcnt_q        <= '0;
            duty_q        <= '0;
            blink_ph_q    <= 1'b0;
            led_q         <= 1'b0;
            period_done_q <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            hcnt_q        <= hcnt_d;
            duty_q        <= duty_d;
            blink_ph_q    <= blink_ph_d;
            led_q         <= led_d;
            period_done_q <= period_done_d;
        end
    end

    assign led         = led_q;
    assign period_done = period_done_q;

endmodule

// File: tb/tb_led_breathe.sv
// Directed bench for led_breathe with PWM_W=4, PRESC=2, HOLD=1
// (one PWM period = 32 clocks, one step per period).
module tb_led_breathe;
    import led_pkg::*;

    localparam int PWM_W = 4;
    localparam int PRESC = 2;
    localparam int HOLD  = 1;
    localparam int LIMIT = 200;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       led;
    logic       period_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_breathe #(
        .PWM_W (PWM_W),
        .PRESC (PRESC),
        .HOLD  (HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .mode        (mode),
        .led         (led),
        .period_done (period_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic until_pd(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_done && n < LIMIT);
    endtask

    task automatic until_led(input logic v, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (led !== v && n < LIMIT);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int n;
        int hi;
        int d;
        bit up;

        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 2'b00;
        repeat (2) @(negedge clk);
        chk("rst_led", led, 0);
        chk("rst_pd", period_done, 0);
        chk("rst_duty", dut.duty_q, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_led", led, 0);

        // solid / off
        en   = 1'b1;
        mode = 2'b01;
        @(negedge clk);
        chk("solid_on", led, 1);
        until_pd(n);
        chk("first_pd", n + 1, 32);
        @(negedge clk);
        chk("pd_pulse", period_done, 0);
        mode = 2'b00;
        @(negedge clk);
        chk("off", led, 0);
        mode = 2'b01;
        @(negedge clk);
        chk("solid_again", led, 1);

        // async reset while led and period_done are both high
        until_pd(n);
        chk("pd_before_rst", period_done, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_led", led, 0);
        chk("async_pd", period_done, 0);
        en   = 1'b0;
        mode = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // blink
        en   = 1'b1;
        mode = 2'b10;
        until_led(1'b1, n);
        chk("blink_rise", n, 33);
        until_led(1'b0, n);
        chk("blink_fall", n, 32);
        until_led(1'b1, n);
        chk("blink_rise2", n, 32);

        // breathe ramp
        do_reset();
        en   = 1'b1;
        mode = 2'b11;
        until_pd(n);
        chk("br_first_pd", n, 32);
        d  = 1;
        up = 1'b1;
        for (int p = 0; p < 31; p++) begin
            hi = 0;
            repeat (32) begin
                @(negedge clk);
                hi += int'(led);
            end
            chk($sformatf("br_hi_p%0d", p), hi, 2 * d);
            chk($sformatf("br_pd_p%0d", p), period_done, 1);
            if (up) begin
                if (d == 15) begin
                    d  = 14;
                    up = 1'b0;
                end else begin
                    d++;
                end
            end else begin
                if (d == 0) begin
                    d  = 1;
                    up = 1'b1;
                end else begin
                    d--;
                end
            end
        end

        // switch breathe -> blink in the step cycle
        repeat (31) @(negedge clk);
        mode = 2'b10;
        @(negedge clk);
        chk("sw_pd", period_done, 1);
        chk("sw_duty", dut.duty_q, 0);
        chk("sw_ph", dut.blink_ph_q, 0);
        chk("sw_led", led, 0);
        until_led(1'b1, n);
        chk("sw_rise", n, 33);

        // en pulse low mid-breathe
        mode = 2'b11;
        repeat (3) until_pd(n);
        repeat (10) @(negedge clk);
        chk("pre_drop_duty", dut.duty_q, 3);
        en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("en_lo_led", led, 0);
            chk("en_lo_pd", period_done, 0);
        end
        chk("en_lo_duty", dut.duty_q, 0);
        chk("en_lo_state", 32'(dut.state_q), 32'(UP));
        en = 1'b1;
        until_pd(n);
        chk("resume_pd", n, 32);
        for (int p = 1; p <= 2; p++) begin
            hi = 0;
            repeat (32) begin
                @(negedge clk);
                hi += int'(led);
            end
            chk($sformatf("resume_hi%0d", p), hi, 2 * p);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
